// File: rtl/xadc_sample_packetizer_pkg.sv
// Shared definitions for the XADC sample packetizer.
package teachee_defs;

  localparam logic [7:0]  XADC_PKT_HEADER = 8'hA5;
  localparam int unsigned XADC_PKT_LEN    = 7;

  typedef logic [2:0] xadc_pkt_idx_t;

  localparam xadc_pkt_idx_t XADC_PKT_LAST_IDX = xadc_pkt_idx_t'(XADC_PKT_LEN - 1);

  typedef enum logic [1:0] {
    WAIT_V = 2'd0,
    WAIT_I = 2'd1,
    EMIT   = 2'd2
  } xadc_packetizer_state_t;

endpackage

// File: rtl/xadc_sample_packetizer_if.sv
// Minimal AXI4-Stream style handshake bundle used by the packetizer.
interface axis_io #(
  parameter int unsigned DATA_W = 16
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport Source (output tdata, output tvalid, output tlast, input  tready);
  modport Sink   (input  tdata, input  tvalid, input  tlast, output tready);
  modport master (output tdata, output tvalid, output tlast, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/xadc_sample_packetizer.sv
// Pairs a voltage sample with the following current sample and emits a
// 7-byte framed packet: header, seq, v_hi, v_lo, i_hi, i_lo, xor checksum.
module xadc_sample_packetizer
  import teachee_defs::*;
#(
  parameter logic [7:0]  HEADER_BYTE  = XADC_PKT_HEADER,
  parameter int unsigned SAMPLE_WIDTH = 16
) (
  input  logic   xadc_dclk,
  input  logic   xadc_reset,
  axis_io.Sink   voltage_channel,
  axis_io.Sink   current_monitor_channel,
  axis_io.Source packet_stream
);

  if (SAMPLE_WIDTH != 16) begin : g_width_check
    $error("xadc_sample_packetizer: SAMPLE_WIDTH must be 16");
  end

  xadc_packetizer_state_t state;
  xadc_pkt_idx_t          byte_idx;
  xadc_pkt_idx_t          next_idx;
  logic [7:0]             seq;
  logic [15:0]            v_reg;
  logic [15:0]            i_reg;
  logic [7:0]             csum;
  logic                   v_ready;
  logic                   i_ready;
  logic [7:0]             out_data;
  logic                   out_valid;
  logic                   out_last;
  logic [7:0]             sel_byte;

  assign voltage_channel.tready         = v_ready;
  assign current_monitor_channel.tready = i_ready;
  assign packet_stream.tdata            = out_data;
  assign packet_stream.tvalid           = out_valid;
  assign packet_stream.tlast            = out_last;

  assign next_idx = byte_idx + xadc_pkt_idx_t'(1);

  // Byte selected for the next output slot; feeds the registered output stage
  always_comb begin
    sel_byte = '0;
    case (next_idx)
      3'd0:    sel_byte = HEADER_BYTE;
      3'd1:    sel_byte = seq;
      3'd2:    sel_byte = v_reg[15:8];
      3'd3:    sel_byte = v_reg[7:0];
      3'd4:    sel_byte = i_reg[15:8];
      3'd5:    sel_byte = i_reg[7:0];
      3'd6:    sel_byte = csum;
      default: sel_byte = '0;
    endcase
  end

  // Pairing FSM, sample capture and registered packet output
  always_ff @(posedge xadc_dclk) begin
    if (!xadc_reset) begin
      state     <= WAIT_V;
      byte_idx  <= '0;
      seq       <= '0;
      v_reg     <= '0;
      i_reg     <= '0;
      csum      <= '0;
      v_ready   <= 1'b0;
      i_ready   <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        WAIT_V: begin
          v_ready <= 1'b1;
          i_ready <= 1'b0;
          if (v_ready && voltage_channel.tvalid) begin
            v_reg   <= voltage_channel.tdata[15:0];
            v_ready <= 1'b0;
            i_ready <= 1'b1;
            state   <= WAIT_I;
          end
        end
        WAIT_I: begin
          v_ready <= 1'b0;
          i_ready <= 1'b1;
          if (i_ready && current_monitor_channel.tvalid) begin
            i_reg     <= current_monitor_channel.tdata[15:0];
            csum      <= seq ^ v_reg[15:8] ^ v_reg[7:0]
                       ^ current_monitor_channel.tdata[15:8]
                       ^ current_monitor_channel.tdata[7:0];
            i_ready   <= 1'b0;
            byte_idx  <= '0;
            out_data  <= HEADER_BYTE;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            state     <= EMIT;
          end
        end
        EMIT: begin
          v_ready <= 1'b0;
          i_ready <= 1'b0;
          if (out_valid && packet_stream.tready) begin
            if (byte_idx == XADC_PKT_LAST_IDX) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
              byte_idx  <= '0;
              seq       <= seq + 8'd1;
              v_ready   <= 1'b1;
              state     <= WAIT_V;
            end else begin
              byte_idx <= next_idx;
              out_data <= sel_byte;
              out_last <= (next_idx == XADC_PKT_LAST_IDX);
            end
          end
        end
        default: begin
          state   <= WAIT_V;
          v_ready <= 1'b0;
          i_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xadc_sample_packetizer.sv
// Directed self-checking bench for xadc_sample_packetizer.
module tb_xadc_sample_packetizer;

  logic xadc_dclk = 1'b0;
  logic xadc_reset = 1'b0;

  always #5 xadc_dclk = ~xadc_dclk;

  axis_io #(.DATA_W(16)) v_if ();
  axis_io #(.DATA_W(16)) i_if ();
  axis_io #(.DATA_W(8))  p_if ();

  xadc_sample_packetizer #(
    .HEADER_BYTE  (8'hA5),
    .SAMPLE_WIDTH (16)
  ) dut (
    .xadc_dclk               (xadc_dclk),
    .xadc_reset              (xadc_reset),
    .voltage_channel         (v_if),
    .current_monitor_channel (i_if),
    .packet_stream           (p_if)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic step();
    @(posedge xadc_dclk);
    #1;
  endtask

  task automatic hold_reset();
    xadc_reset  = 1'b0;
    v_if.tvalid = 1'b0; v_if.tdata = '0; v_if.tlast = 1'b0;
    i_if.tvalid = 1'b0; i_if.tdata = '0; i_if.tlast = 1'b0;
    p_if.tready = 1'b0;
    repeat (3) step();
  endtask

  task automatic release_reset();
    xadc_reset = 1'b1;
    step();
  endtask

  task automatic send_v(input logic [15:0] d, output bit ok);
    v_if.tdata  = d;
    v_if.tvalid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      if (v_if.tready === 1'b1) ok = 1'b1;
      step();
    end
    v_if.tvalid = 1'b0;
  endtask

  task automatic send_i(input logic [15:0] d, output bit ok);
    i_if.tdata  = d;
    i_if.tvalid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      if (i_if.tready === 1'b1) ok = 1'b1;
      step();
    end
    i_if.tvalid = 1'b0;
  endtask

  // Collects one packet with a repeating tready pattern (bit k = cycle k)
  task automatic collect(input logic [3:0] pat, input int unsigned plen,
                         output logic [55:0] got, output bit last_ok,
                         output bit stable_ok, output bit done);
    int unsigned n = 0;
    int unsigned cyc = 0;
    int unsigned k;
    logic [7:0]  held;
    logic        held_last;
    bit          stalled = 1'b0;
    got = '0; last_ok = 1'b1; stable_ok = 1'b1; held = '0; held_last = 1'b0;
    while (n < 7 && cyc < 200) begin
      k = cyc % plen;
      p_if.tready = pat[k[1:0]];
      if (stalled && (p_if.tdata !== held || p_if.tlast !== held_last)) stable_ok = 1'b0;
      stalled = 1'b0;
      if (p_if.tvalid === 1'b1 && p_if.tready) begin
        got = {got[47:0], p_if.tdata};
        if (p_if.tlast !== (n == 6)) last_ok = 1'b0;
        n++;
      end else if (p_if.tvalid === 1'b1) begin
        stalled   = 1'b1;
        held      = p_if.tdata;
        held_last = p_if.tlast;
      end
      step();
      cyc++;
    end
    p_if.tready = 1'b0;
    done = (n == 7);
  endtask

  task automatic test_reset();
    hold_reset();
    total++; if (v_if.tready !== 1'b0) begin bad++; $display("FAIL rst_v_tready: got %b want 0", v_if.tready); end
    total++; if (i_if.tready !== 1'b0) begin bad++; $display("FAIL rst_i_tready: got %b want 0", i_if.tready); end
    total++; if (p_if.tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid: got %b want 0", p_if.tvalid); end
    total++; if (p_if.tlast !== 1'b0) begin bad++; $display("FAIL rst_tlast: got %b want 0", p_if.tlast); end
    total++; if (p_if.tdata !== 8'h00) begin bad++; $display("FAIL rst_tdata: got %h want 00", p_if.tdata); end
    release_reset();
  endtask

  task automatic test_basic();
    bit ok_v, ok_i, last_ok, stable_ok, done;
    logic [55:0] got;
    send_v(16'h1234, ok_v);
    send_i(16'hABCD, ok_i);
    total++; if (!(ok_v && ok_i)) begin bad++; $display("FAIL basic1_handshake: got v=%b i=%b want 1 1", ok_v, ok_i); end
    total++; if (p_if.tvalid !== 1'b1 || p_if.tdata !== 8'hA5) begin
      bad++; $display("FAIL basic1_latency: got valid=%b data=%h want 1 a5", p_if.tvalid, p_if.tdata); end
    collect(4'b0001, 1, got, last_ok, stable_ok, done);
    total++; if (!done) begin bad++; $display("FAIL basic1_timeout: got done=0 want 1"); end
    total++; if (got !== 56'hA5_00_12_34_AB_CD_40) begin bad++; $display("FAIL basic1_bytes: got %h want a5001234abcd40", got); end
    total++; if (!last_ok) begin bad++; $display("FAIL basic1_tlast: got misplaced want byte6 only"); end
    total++; if (v_if.tready !== 1'b1 || p_if.tvalid !== 1'b0) begin
      bad++; $display("FAIL basic1_return: got v_tready=%b tvalid=%b want 1 0", v_if.tready, p_if.tvalid); end

    send_v(16'h0000, ok_v);
    send_i(16'hFFFF, ok_i);
    total++; if (!(ok_v && ok_i)) begin bad++; $display("FAIL basic2_handshake: got v=%b i=%b want 1 1", ok_v, ok_i); end
    collect(4'b0001, 1, got, last_ok, stable_ok, done);
    total++; if (got !== 56'hA5_01_00_00_FF_FF_01 || !done) begin bad++; $display("FAIL basic2_bytes: got %h want a50100 00ffff01", got); end
    total++; if (!last_ok) begin bad++; $display("FAIL basic2_tlast: got misplaced want byte6 only"); end
  endtask

  task automatic test_current_first();
    bit ok_v, i_stuck, last_ok, stable_ok, done;
    logic [55:0] got;
    hold_reset();
    i_if.tdata  = 16'h5555;
    i_if.tvalid = 1'b1;
    release_reset();
    i_stuck = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (i_if.tready !== 1'b0 || p_if.tvalid !== 1'b0) i_stuck = 1'b1;
      step();
    end
    total++; if (i_stuck) begin bad++; $display("FAIL ifirst_blocked: got i_tready/tvalid high want 0"); end
    send_v(16'h0001, ok_v);
    total++; if (!ok_v || i_if.tready !== 1'b1) begin bad++; $display("FAIL ifirst_i_ready: got ok=%b i_tready=%b want 1 1", ok_v, i_if.tready); end
    step();
    i_if.tvalid = 1'b0;
    total++; if (p_if.tvalid !== 1'b1 || p_if.tdata !== 8'hA5) begin
      bad++; $display("FAIL ifirst_start: got valid=%b data=%h want 1 a5", p_if.tvalid, p_if.tdata); end
    collect(4'b0001, 1, got, last_ok, stable_ok, done);
    total++; if (got !== 56'hA5_00_00_01_55_55_01 || !done || !last_ok) begin
      bad++; $display("FAIL ifirst_bytes: got %h last_ok=%b want a5000001555501 1", got, last_ok); end
  endtask

  task automatic test_stall();
    bit ok_v, ok_i, last_ok, stable_ok, done;
    logic [55:0] got;
    send_v(16'hBEEF, ok_v);
    send_i(16'h0102, ok_i);
    collect(4'b1001, 4, got, last_ok, stable_ok, done);
    total++; if (!(ok_v && ok_i) || !done) begin bad++; $display("FAIL stall_timeout: got v=%b i=%b done=%b want 1 1 1", ok_v, ok_i, done); end
    total++; if (got !== 56'hA5_01_BE_EF_01_02_53) begin bad++; $display("FAIL stall_bytes: got %h want a501beef010253", got); end
    total++; if (!stable_ok) begin bad++; $display("FAIL stall_stable: got changed want held"); end
    total++; if (!last_ok) begin bad++; $display("FAIL stall_tlast: got misplaced want byte6 only"); end
  endtask

  task automatic test_wrap();
    bit ok_v, ok_i, last_ok, stable_ok, done;
    logic [55:0] got, want;
    logic [7:0]  s, vh, vl;
    hold_reset();
    release_reset();
    for (int k = 0; k < 257; k++) begin
      s  = 8'(k);
      vh = 8'(k);
      vl = ~8'(k);
      send_v({vh, vl}, ok_v);
      send_i(16'h5AA5, ok_i);
      collect(4'b0001, 1, got, last_ok, stable_ok, done);
      want = {8'hA5, s, vh, vl, 8'h5A, 8'hA5, s ^ vh ^ vl ^ 8'h5A ^ 8'hA5};
      total++;
      if (got !== want || !done || !last_ok || !ok_v || !ok_i) begin
        bad++; $display("FAIL wrap_pkt%0d: got %h want %h", k, got, want);
      end
    end
  endtask

  task automatic test_mid_reset();
    bit ok_v, ok_i, last_ok, stable_ok, done;
    logic [55:0] got;
    send_v(16'h1111, ok_v);
    send_i(16'h2222, ok_i);
    p_if.tready = 1'b1;
    repeat (4) step();
    xadc_reset = 1'b0;
    step();
    total++; if (p_if.tvalid !== 1'b0 || p_if.tlast !== 1'b0) begin
      bad++; $display("FAIL midrst_abort: got tvalid=%b tlast=%b want 0 0", p_if.tvalid, p_if.tlast); end
    p_if.tready = 1'b0;
    release_reset();
    send_v(16'h7777, ok_v);
    send_i(16'h8888, ok_i);
    collect(4'b0001, 1, got, last_ok, stable_ok, done);
    total++; if (got !== 56'hA5_00_77_77_88_88_00 || !done || !last_ok) begin
      bad++; $display("FAIL midrst_fresh: got %h last_ok=%b want a5007777888800 1", got, last_ok); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_current_first();
    test_stall();
    test_wrap();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
